// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU command/accumulator stage.
//   - default data/op widths and command FIFO depth
//   - FSM state encoding
//   - command word layout {load, op, imm}, load in the MSB
package alu_pkg;

  localparam int WIDTH = 4;
  localparam int OPW   = 3;
  localparam int DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Reference layout at the default widths; the RTL slices the same
  // layout by parameter so non-default widths keep the same ordering.
  typedef struct packed {
    logic             load;
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] imm;
  } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous first-word-fall-through FIFO for queued commands.
// Ports:
//   clk, rst         clock, async active-high reset (empties the FIFO)
//   push_i, din_i    write request / data (ignored when full)
//   pop_i, dout_o    read request / head-of-queue data (ignored when empty)
//   full_o, empty_o  occupancy flags
module cmd_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]   wr_q, rd_q;
  logic [DW-1:0] mem_q [DEPTH];
  logic          do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  // Full blocks a push even if a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/alu_acc_ctrl.sv
// alu_acc_ctrl: command/accumulator stage in front of a combinational ALU.
// Commands are queued, executed one at a time (IDLE -> EXEC -> RESP), and
// each new accumulator value is returned on a valid/ready response port.
// Ports:
//   clk, rst                          clock, async active-high reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_load, cmd_op, cmd_imm         command fields
//   alu_a, alu_b, alu_s / alu_y       ALU operands out / result in
//   res_valid/res_ready, res_data     response handshake and data
module alu_acc_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int OPW   = alu_pkg::OPW,
  parameter int DEPTH = alu_pkg::DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [OPW-1:0]   cmd_op,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_s,
  input  logic [WIDTH-1:0] alu_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data
);

  localparam int CW = 1 + OPW + WIDTH;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OPW-1:0]   s_q, s_d;
  logic             load_q, load_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;

  logic [CW-1:0]    fifo_dout;
  logic             fifo_full, fifo_empty, fifo_pop;

  cmd_fifo #(
    .DW    (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid && cmd_ready),
    .din_i   ({cmd_load, cmd_op, cmd_imm}),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Ready is forced low during reset so nothing is taken while flushing.
  assign cmd_ready = !rst && !fifo_full;

  assign alu_a     = acc_q;
  assign alu_b     = b_q;
  assign alu_s     = s_q;
  assign res_valid = rvalid_q;
  assign res_data  = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      b_q      <= '0;
      s_q      <= '0;
      load_q   <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      s_q      <= s_d;
      load_q   <= load_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    b_d      = b_q;
    s_d      = s_q;
    load_d   = load_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          load_d   = fifo_dout[CW-1];
          s_d      = fifo_dout[WIDTH +: OPW];
          b_d      = fifo_dout[WIDTH-1:0];
          state_d  = EXEC;
        end
      end
      EXEC: begin
        // Load bypasses the ALU; otherwise take its result verbatim (no carry).
        acc_d    = load_q ? b_q : alu_y;
        rdata_d  = acc_d;
        rvalid_d = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        if (res_ready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_acc_ctrl.sv
module tb_alu_acc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_load;
  logic [2:0] cmd_op;
  logic [3:0] cmd_imm;
  logic [3:0] alu_a, alu_b, alu_y, res_data;
  logic [2:0] alu_s;
  logic       res_valid, res_ready;

  int errors = 0;
  int checks = 0;

  alu_acc_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_load  (cmd_load),
    .cmd_op    (cmd_op),
    .cmd_imm   (cmd_imm),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_s     (alu_s),
    .alu_y     (alu_y),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
  );

  // Behavioural ALU stub: add for every select.
  assign alu_y = alu_a + alu_b;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one command for exactly one edge (caller ensures cmd_ready).
  task automatic send(input logic ld, input logic [2:0] op, input logic [3:0] imm);
    cmd_valid = 1'b1;
    cmd_load  = ld;
    cmd_op    = op;
    cmd_imm   = imm;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Execute one command and consume its response; checks EXEC operands
  // and the result.
  task automatic run(input string tag, input logic ld, input logic [2:0] op,
                     input logic [3:0] imm, input logic [3:0] a_exp,
                     input logic [3:0] y_exp);
    send(ld, op, imm);
    tick();
    chk({tag, "_exec_a"}, alu_a, a_exp);
    chk({tag, "_exec_b"}, alu_b, imm);
    chk({tag, "_exec_s"}, alu_s, op);
    chk({tag, "_exec_nvld"}, res_valid, 1'b0);
    tick();
    chk({tag, "_vld"}, res_valid, 1'b1);
    chk({tag, "_data"}, res_data, y_exp);
    chk({tag, "_acc"}, alu_a, y_exp);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_done"}, res_valid, 1'b0);
  endtask

  initial begin
    logic [3:0] exp_q [6];
    int k;
    bit acc_now, rsp_now;

    rst = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = '0; cmd_imm = '0;
    res_ready = 1'b0;
    #12;
    chk("rst_ready", cmd_ready, 1'b0);
    chk("rst_vld", res_valid, 1'b0);
    chk("rst_acc", alu_a, 4'h0);
    rst = 1'b0;
    #2;
    chk("rel_ready", cmd_ready, 1'b1);
    tick();

    // Load bypass, then accumulate, then wrap.
    run("load8", 1'b1, 3'b000, 4'b1000, 4'h0, 4'b1000);
    run("add6", 1'b0, 3'b000, 4'b0110, 4'b1000, 4'b1110);
    run("loadC", 1'b1, 3'b101, 4'b1100, 4'b1110, 4'b1100);
    run("wrap", 1'b0, 3'b011, 4'b0111, 4'b1100, 4'b0011);

    // Async reset mid-cycle while holding a response with non-zero state.
    send(1'b1, 3'b110, 4'b1001);
    tick(); tick();
    chk("pre_rst_vld", res_valid, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_vld", res_valid, 1'b0);
    chk("arst_data", res_data, 4'h0);
    chk("arst_a", alu_a, 4'h0);
    chk("arst_b", alu_b, 4'h0);
    chk("arst_s", alu_s, 3'h0);
    chk("arst_ready", cmd_ready, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_rel_ready", cmd_ready, 1'b1);
    tick();

    // Backpressure: six commands with res_ready low.
    exp_q = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_ready%0d", i), cmd_ready, 1'b1);
      send(i == 0, 3'b010, 4'd1);
    end
    chk("bp_full", cmd_ready, 1'b0);
    chk("bp_vld", res_valid, 1'b1);
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 3'b010; cmd_imm = 4'd1;
    for (int i = 0; i < 3; i++) tick();
    chk("bp_stall_ready", cmd_ready, 1'b0);
    chk("bp_hold_data", res_data, 4'd1);
    chk("bp_hold_acc", alu_a, 4'd1);
    chk("bp_hold_s", alu_s, 3'b010);
    res_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 60 && k < 6; c++) begin
      acc_now = cmd_valid && cmd_ready;
      rsp_now = res_valid && res_ready;
      if (rsp_now) begin
        chk($sformatf("bp_res%0d", k), res_data, exp_q[k]);
        k++;
      end
      tick();
      if (acc_now) cmd_valid = 1'b0;
    end
    chk("bp_count", k, 6);
    chk("bp_cmd_taken", cmd_valid, 1'b0);
    res_ready = 1'b0;
    tick();

    // Reset during EXEC with a second command queued: both discarded.
    send(1'b1, 3'b000, 4'd5);
    send(1'b1, 3'b000, 4'd7);
    chk("r6_exec_b", alu_b, 4'd5);
    #3;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("r6_vld", res_valid, 1'b0);
    chk("r6_acc", alu_a, 4'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("r6_quiet%0d", i), res_valid, 1'b0);
    end
    run("r6_next", 1'b0, 3'b001, 4'd3, 4'h0, 4'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
